ocimem_access_arbiter: RTL and testbench

Shares the single-port on-chip debug memory (OCI RAM) between two requesters:
- the JTAG debug path, driven by the sysclk-side take_action strobes and jdo fields;
- the CPU-side Avalon-MM debug slave.

The block contains a JTAG auto-incrementing address counter, a round-robin grant and a read-return tag pipeline, so each requester gets its read data back in order. It sits between the debug module's sysclk domain logic and the OCI RAM instance.

---
 rtl/ocimem_arb_pkg.sv | 21 ++
 rtl/rr_arbiter2.sv | 39 +++
 rtl/ocimem_access_arbiter.sv | 160 ++++++++++++++++
 tb/tb_ocimem_access_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ocimem_arb_pkg.sv
// rtl/ocimem_arb_pkg.sv - shared types and defaults for the OCI RAM access arbiter
package ocimem_arb_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 32;

  // Which side of the arbiter an access belongs to
  typedef enum logic {
    REQ_JTAG = 1'b0,
    REQ_AVS  = 1'b1
  } req_t;

  // Read-return tag travelling alongside an outstanding RAM read
  typedef struct packed {
    logic valid;
    req_t req;
  } tag_t;

  localparam tag_t TAG_NONE = '{valid: 1'b0, req: REQ_JTAG};

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-request round-robin arbiter with a last-grant register
module rr_arbiter2 #(
  parameter logic RESET_LAST_B = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic req_a,
  input  logic req_b,
  output logic grant_a,
  output logic grant_b
);

  logic last_b;

  // A lone requester always wins; on a tie the side not granted last wins
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (req_a && req_b) begin
      grant_a = last_b;
      grant_b = ~last_b;
    end else begin
      grant_a = req_a;
      grant_b = req_b;
    end
  end

  // Remember the most recent winner; idle cycles leave it unchanged
  always_ff @(posedge clk) begin
    if (reset) begin
      last_b <= RESET_LAST_B;
    end else if (grant_a) begin
      last_b <= 1'b0;
    end else if (grant_b) begin
      last_b <= 1'b1;
    end
  end

endmodule

// File: rtl/ocimem_access_arbiter.sv
// rtl/ocimem_access_arbiter.sv - shares the OCI RAM between the JTAG debug path and the Avalon slave
module ocimem_access_arbiter
  import ocimem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              jtag_addr_load,
  input  logic [ADDR_W-1:0] jtag_addr,
  input  logic              jtag_rd,
  input  logic              jtag_wr,
  input  logic [DATA_W-1:0] jtag_wdata,
  output logic [DATA_W-1:0] jtag_rdata,
  output logic              jtag_rdata_valid,
  output logic              jtag_busy,
  output logic              jtag_overrun,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  output logic              avs_waitrequest,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              avs_readdatavalid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  logic [ADDR_W-1:0] jtag_cnt;
  logic              pending;
  logic              pend_wr;
  logic [DATA_W-1:0] pend_wdata;
  logic              overrun;
  logic [DATA_W-1:0] jtag_hold;

  tag_t tags [RD_LAT];
  tag_t issue_tag;
  tag_t ret_tag;

  logic jtag_req;
  logic avs_req;
  logic jtag_grant;
  logic avs_grant;
  logic jtag_ret;
  logic avs_ret;
  logic jtag_inflight;

  // A counter reload in the same cycle cancels the pending op, so it must not issue
  assign jtag_req = pending & ~jtag_addr_load & ~reset;
  assign avs_req  = (avs_read | avs_write) & ~reset;

  rr_arbiter2 #(
    .RESET_LAST_B(1'b1)
  ) u_rr (
    .clk    (clk),
    .reset  (reset),
    .req_a  (jtag_req),
    .req_b  (avs_req),
    .grant_a(jtag_grant),
    .grant_b(avs_grant)
  );

  // Drive the RAM port from whichever requester won this cycle
  always_comb begin
    ram_addr  = '0;
    ram_wren  = 1'b0;
    ram_wdata = '0;
    issue_tag = TAG_NONE;
    if (jtag_grant) begin
      ram_addr      = jtag_cnt;
      ram_wren      = pend_wr;
      ram_wdata     = pend_wdata;
      issue_tag.valid = ~pend_wr;
      issue_tag.req   = REQ_JTAG;
    end else if (avs_grant) begin
      ram_addr      = avs_address;
      ram_wren      = avs_write;
      ram_wdata     = avs_writedata;
      issue_tag.valid = ~avs_write;
      issue_tag.req   = REQ_AVS;
    end
  end

  assign avs_waitrequest = avs_req & ~avs_grant;

  // Shift read tags so each one meets its data at the RAM output RD_LAT cycles later
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) tags[i] <= TAG_NONE;
    end else begin
      tags[0] <= issue_tag;
      for (int i = 1; i < RD_LAT; i++) tags[i] <= tags[i-1];
    end
  end

  assign ret_tag  = tags[RD_LAT-1];
  assign jtag_ret = ret_tag.valid & (ret_tag.req == REQ_JTAG) & ~reset;
  assign avs_ret  = ret_tag.valid & (ret_tag.req == REQ_AVS) & ~reset;

  assign jtag_rdata_valid  = jtag_ret;
  assign jtag_rdata        = jtag_ret ? ram_rdata : jtag_hold;
  assign avs_readdatavalid = avs_ret;
  assign avs_readdata      = avs_ret ? ram_rdata : '0;

  // Keep the last JTAG read word visible for MonDReg until the next one lands
  always_ff @(posedge clk) begin
    if (reset) begin
      jtag_hold <= '0;
    end else if (jtag_ret) begin
      jtag_hold <= ram_rdata;
    end
  end

  // Any JTAG read still travelling through the tag pipe keeps the JTAG side busy
  always_comb begin
    jtag_inflight = 1'b0;
    for (int i = 0; i < RD_LAT; i++) begin
      if (tags[i].valid && (tags[i].req == REQ_JTAG)) jtag_inflight = 1'b1;
    end
  end

  assign jtag_busy    = pending | jtag_inflight;
  assign jtag_overrun = overrun;

  // JTAG address counter, single-entry op slot and sticky overrun flag
  always_ff @(posedge clk) begin
    if (reset) begin
      jtag_cnt   <= '0;
      pending    <= 1'b0;
      pend_wr    <= 1'b0;
      pend_wdata <= '0;
      overrun    <= 1'b0;
    end else if (jtag_addr_load) begin
      jtag_cnt   <= jtag_addr;
      overrun    <= 1'b0;
      pending    <= jtag_rd | jtag_wr;
      pend_wr    <= jtag_wr;
      pend_wdata <= jtag_wdata;
    end else begin
      if (jtag_grant) begin
        jtag_cnt <= jtag_cnt + 1'b1;
        pending  <= 1'b0;
      end
      if (jtag_rd || jtag_wr) begin
        if (pending) begin
          overrun <= 1'b1;
        end else begin
          pending    <= 1'b1;
          pend_wr    <= jtag_wr;
          pend_wdata <= jtag_wdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_ocimem_access_arbiter.sv
// tb/tb_ocimem_access_arbiter.sv - self-checking bench for ocimem_access_arbiter at RD_LAT 1 and 2
module tb_ocimem_access_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic          jtag_addr_load = 1'b0;
  logic [AW-1:0] jtag_addr = '0;
  logic          jtag_rd = 1'b0;
  logic          jtag_wr = 1'b0;
  logic [DW-1:0] jtag_wdata = '0;
  logic [AW-1:0] avs_address = '0;
  logic          avs_read = 1'b0;
  logic          avs_write = 1'b0;
  logic [DW-1:0] avs_writedata = '0;

  logic [DW-1:0] jtag_rdata_o [2];
  logic          jtag_rdata_valid_o [2];
  logic          jtag_busy_o [2];
  logic          jtag_overrun_o [2];
  logic          avs_waitrequest_o [2];
  logic [DW-1:0] avs_readdata_o [2];
  logic          avs_readdatavalid_o [2];
  logic [AW-1:0] ram_addr_o [2];
  logic          ram_wren_o [2];
  logic [DW-1:0] ram_wdata_o [2];
  logic [DW-1:0] ram_rdata_i [2];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  ocimem_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) u_dut_lat1 (
    .clk(clk), .reset(reset),
    .jtag_addr_load(jtag_addr_load), .jtag_addr(jtag_addr),
    .jtag_rd(jtag_rd), .jtag_wr(jtag_wr), .jtag_wdata(jtag_wdata),
    .jtag_rdata(jtag_rdata_o[0]), .jtag_rdata_valid(jtag_rdata_valid_o[0]),
    .jtag_busy(jtag_busy_o[0]), .jtag_overrun(jtag_overrun_o[0]),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_waitrequest(avs_waitrequest_o[0]),
    .avs_readdata(avs_readdata_o[0]), .avs_readdatavalid(avs_readdatavalid_o[0]),
    .ram_addr(ram_addr_o[0]), .ram_wren(ram_wren_o[0]), .ram_wdata(ram_wdata_o[0]),
    .ram_rdata(ram_rdata_i[0])
  );

  ocimem_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(2)) u_dut_lat2 (
    .clk(clk), .reset(reset),
    .jtag_addr_load(jtag_addr_load), .jtag_addr(jtag_addr),
    .jtag_rd(jtag_rd), .jtag_wr(jtag_wr), .jtag_wdata(jtag_wdata),
    .jtag_rdata(jtag_rdata_o[1]), .jtag_rdata_valid(jtag_rdata_valid_o[1]),
    .jtag_busy(jtag_busy_o[1]), .jtag_overrun(jtag_overrun_o[1]),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_waitrequest(avs_waitrequest_o[1]),
    .avs_readdata(avs_readdata_o[1]), .avs_readdatavalid(avs_readdatavalid_o[1]),
    .ram_addr(ram_addr_o[1]), .ram_wren(ram_wren_o[1]), .ram_wdata(ram_wdata_o[1]),
    .ram_rdata(ram_rdata_i[1])
  );

  // OCI RAM stand-ins: write-then-read single port, output delayed by RD_LAT
  for (genvar g = 0; g < 2; g++) begin : g_ram
    logic [DW-1:0] mem [256];
    logic [DW-1:0] q1 = '0;
    logic [DW-1:0] q2 = '0;
    initial for (int a = 0; a < 256; a++) mem[a] = '0;
    always @(posedge clk) begin
      q1 <= mem[ram_addr_o[g]];
      q2 <= q1;
      if (ram_wren_o[g]) mem[ram_addr_o[g]] <= ram_wdata_o[g];
    end
    assign ram_rdata_i[g] = (g == 0) ? q1 : q2;
  end

  task automatic chk(input string name, input int inst, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d actual=%0h expected=%0h at cycle %0d", name, inst, act, exp, cyc);
    end
  endtask

  // Reference model: op slot, counter, round-robin state, shadow memory and a
  // return schedule keyed by absolute cycle number.
  logic [DW-1:0] m_mem [2][256];
  logic [AW-1:0] m_cnt [2];
  bit            m_pend [2];
  bit            m_pwr [2];
  logic [DW-1:0] m_pwd [2];
  bit            m_ovr [2];
  bit            m_last_avs [2];
  logic [DW-1:0] m_hold [2];
  bit            m_sv [2][4];
  bit            m_sa [2][4];
  logic [DW-1:0] m_sd [2][4];

  initial for (int i = 0; i < 2; i++) for (int a = 0; a < 256; a++) m_mem[i][a] = '0;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = '0; m_pend[i] = 0; m_pwr[i] = 0; m_pwd[i] = '0;
      m_ovr[i] = 0; m_last_avs[i] = 1; m_hold[i] = '0;
      for (int s = 0; s < 4; s++) begin m_sv[i][s] = 0; m_sa[i][s] = 0; m_sd[i][s] = '0; end
    end
  endtask

  task automatic model_step(input int i);
    int lat, now_s, slot;
    bit jr, ar, gj, ga, ret_v, ret_avs, busy;
    logic [DW-1:0] ret_d, e_wdata;
    logic [AW-1:0] e_addr;
    bit e_wren;
    lat = i + 1;
    now_s = cyc % 4;
    jr = m_pend[i] && !jtag_addr_load;
    ar = avs_read || avs_write;
    gj = (jr && ar) ? m_last_avs[i] : jr;
    ga = ar && !gj;
    e_addr  = gj ? m_cnt[i] : (ga ? avs_address : '0);
    e_wren  = gj ? m_pwr[i] : (ga ? avs_write : 1'b0);
    e_wdata = gj ? m_pwd[i] : (ga ? avs_writedata : '0);
    ret_v = m_sv[i][now_s]; ret_avs = m_sa[i][now_s]; ret_d = m_sd[i][now_s];
    busy = m_pend[i];
    for (int s = 0; s < 4; s++) if (m_sv[i][s] && !m_sa[i][s]) busy = 1;

    chk("ram_addr", i, 64'(ram_addr_o[i]), 64'(e_addr));
    chk("ram_wren", i, 64'(ram_wren_o[i]), 64'(e_wren));
    if (e_wren) chk("ram_wdata", i, 64'(ram_wdata_o[i]), 64'(e_wdata));
    chk("avs_waitrequest", i, 64'(avs_waitrequest_o[i]), 64'(ar && !ga));
    chk("avs_readdatavalid", i, 64'(avs_readdatavalid_o[i]), 64'(ret_v && ret_avs));
    chk("avs_readdata", i, 64'(avs_readdata_o[i]), (ret_v && ret_avs) ? 64'(ret_d) : 64'd0);
    chk("jtag_rdata_valid", i, 64'(jtag_rdata_valid_o[i]), 64'(ret_v && !ret_avs));
    chk("jtag_rdata", i, 64'(jtag_rdata_o[i]), (ret_v && !ret_avs) ? 64'(ret_d) : 64'(m_hold[i]));
    chk("jtag_busy", i, 64'(jtag_busy_o[i]), 64'(busy));
    chk("jtag_overrun", i, 64'(jtag_overrun_o[i]), 64'(m_ovr[i]));

    m_sv[i][now_s] = 0;
    if (ret_v && !ret_avs) m_hold[i] = ret_d;
    if ((gj && !m_pwr[i]) || (ga && !avs_write)) begin
      slot = (cyc + lat) % 4;
      m_sv[i][slot] = 1; m_sa[i][slot] = ga; m_sd[i][slot] = m_mem[i][e_addr];
    end
    if (e_wren) m_mem[i][e_addr] = e_wdata;
    if (gj) m_last_avs[i] = 0;
    else if (ga) m_last_avs[i] = 1;
    if (jtag_addr_load) begin
      m_cnt[i] = jtag_addr; m_ovr[i] = 0;
      m_pend[i] = jtag_rd || jtag_wr; m_pwr[i] = jtag_wr; m_pwd[i] = jtag_wdata;
    end else begin
      bit was_pend;
      was_pend = m_pend[i];
      if (gj) begin m_cnt[i] = m_cnt[i] + 8'd1; m_pend[i] = 0; end
      if (jtag_rd || jtag_wr) begin
        if (was_pend) m_ovr[i] = 1;
        else begin m_pend[i] = 1; m_pwr[i] = jtag_wr; m_pwd[i] = jtag_wdata; end
      end
    end
  endtask

  // Compare both instances against the model on every out-of-reset cycle
  always @(negedge clk) begin
    if (reset) model_reset();
    else for (int i = 0; i < 2; i++) model_step(i);
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    idle(3);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", 0, 64'(jtag_busy_o[0]), 64'd0);
    chk("rst_overrun", 0, 64'(jtag_overrun_o[0]), 64'd0);
    chk("rst_jtag_rdata", 0, 64'(jtag_rdata_o[0]), 64'd0);
    chk("rst_wren", 0, 64'(ram_wren_o[0]), 64'd0);

    // JTAG write at a loaded address, then confirm the counter advanced
    step(); jtag_addr_load = 1'b1; jtag_addr = 8'h10;
    step(); jtag_addr_load = 1'b0; jtag_wr = 1'b1; jtag_wdata = 32'hDEADBEEF;
    step(); jtag_wr = 1'b0;
    @(negedge clk);
    chk("t1_wren", 0, 64'(ram_wren_o[0]), 64'd1);
    chk("t1_addr", 0, 64'(ram_addr_o[0]), 64'h10);
    chk("t1_wdata", 0, 64'(ram_wdata_o[0]), 64'hDEADBEEF);
    step(); jtag_rd = 1'b1;
    @(negedge clk);
    chk("t1_busy_after", 0, 64'(jtag_busy_o[0]), 64'd0);
    step(); jtag_rd = 1'b0;
    @(negedge clk);
    chk("t1_cnt_next", 0, 64'(ram_addr_o[0]), 64'h11);
    idle(3);

    // JTAG read-back of the word just written
    jtag_addr_load = 1'b1; jtag_addr = 8'h10;
    step(); jtag_addr_load = 1'b0; jtag_rd = 1'b1;
    step(); jtag_rd = 1'b0;
    step();
    @(negedge clk);
    chk("t2_valid", 0, 64'(jtag_rdata_valid_o[0]), 64'd1);
    chk("t2_rdata", 0, 64'(jtag_rdata_o[0]), 64'hDEADBEEF);
    step();
    @(negedge clk);
    chk("t2_valid_drop", 0, 64'(jtag_rdata_valid_o[0]), 64'd0);
    chk("t2_rdata_hold", 0, 64'(jtag_rdata_o[0]), 64'hDEADBEEF);
    idle(2);

    // Counter wrap from 0xFF to 0x00
    jtag_addr_load = 1'b1; jtag_addr = 8'hFF;
    step(); jtag_addr_load = 1'b0; jtag_rd = 1'b1;
    step(); jtag_rd = 1'b0;
    @(negedge clk);
    chk("t3_addr_ff", 0, 64'(ram_addr_o[0]), 64'hFF);
    step(); jtag_wr = 1'b1; jtag_wdata = 32'hCAFEF00D;
    step(); jtag_wr = 1'b0;
    @(negedge clk);
    chk("t3_wrap_addr", 0, 64'(ram_addr_o[0]), 64'h00);
    chk("t3_wrap_wren", 0, 64'(ram_wren_o[0]), 64'd1);
    idle(3);

    // Avalon read held while JTAG reads every other cycle: grants alternate
    jtag_addr_load = 1'b1; jtag_addr = 8'h00;
    step(); jtag_addr_load = 1'b0; avs_read = 1'b1; avs_address = 8'h10; jtag_rd = 1'b1;
    @(negedge clk);
    chk("t4_s0_wait", 0, 64'(avs_waitrequest_o[0]), 64'd0);
    step(); jtag_rd = 1'b0;
    @(negedge clk);
    chk("t4_s1_wait", 0, 64'(avs_waitrequest_o[0]), 64'd1);
    chk("t4_s1_addr", 0, 64'(ram_addr_o[0]), 64'h00);
    chk("t4_s1_avs_valid", 0, 64'(avs_readdatavalid_o[0]), 64'd1);
    chk("t4_s1_avs_data", 0, 64'(avs_readdata_o[0]), 64'hDEADBEEF);
    step(); jtag_rd = 1'b1;
    @(negedge clk);
    chk("t4_s2_wait", 0, 64'(avs_waitrequest_o[0]), 64'd0);
    chk("t4_s2_jtag_valid", 0, 64'(jtag_rdata_valid_o[0]), 64'd1);
    chk("t4_s2_jtag_data", 0, 64'(jtag_rdata_o[0]), 64'hCAFEF00D);
    for (int k = 3; k < 8; k++) begin
      step(); jtag_rd = (k % 2 == 0);
    end
    step(); jtag_rd = 1'b0; avs_read = 1'b0;
    idle(3);

    // Overrun: JTAG loses a tie with an op still pending, a second op is dropped
    jtag_rd = 1'b1;
    step(); jtag_rd = 1'b0;
    step(); jtag_rd = 1'b1;
    step(); avs_read = 1'b1;
    @(negedge clk);
    chk("t5_avs_wins_tie", 0, 64'(avs_waitrequest_o[0]), 64'd0);
    step(); jtag_rd = 1'b0;
    @(negedge clk);
    chk("t5_overrun_set", 0, 64'(jtag_overrun_o[0]), 64'd1);
    chk("t5_jtag_granted", 0, 64'(avs_waitrequest_o[0]), 64'd1);
    step();
    @(negedge clk);
    chk("t5_avs_granted", 0, 64'(avs_waitrequest_o[0]), 64'd0);
    step(); avs_read = 1'b0; jtag_addr_load = 1'b1; jtag_addr = 8'h30;
    @(negedge clk);
    chk("t5_single_issue", 0, 64'(jtag_busy_o[0]), 64'd0);
    step(); jtag_addr_load = 1'b0;
    @(negedge clk);
    chk("t5_overrun_clr", 0, 64'(jtag_overrun_o[0]), 64'd0);
    idle(3);

    // Reset one cycle after an Avalon read is accepted: RD_LAT=2 return is dropped
    avs_read = 1'b1; avs_address = 8'h10;
    step(); avs_read = 1'b0; reset = 1'b1;
    step(); reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("t6_avs_valid", i, 64'(avs_readdatavalid_o[i]), 64'd0);
      chk("t6_avs_data", i, 64'(avs_readdata_o[i]), 64'd0);
      chk("t6_jtag_rdata", i, 64'(jtag_rdata_o[i]), 64'd0);
      chk("t6_busy", i, 64'(jtag_busy_o[i]), 64'd0);
      chk("t6_wren", i, 64'(ram_wren_o[i]), 64'd0);
    end
    step(); jtag_wr = 1'b1; jtag_wdata = 32'h00000055;
    step(); jtag_wr = 1'b0;
    @(negedge clk);
    chk("t6_cnt_zero", 0, 64'(ram_addr_o[0]), 64'h00);
    chk("t6_cnt_wren", 0, 64'(ram_wren_o[0]), 64'd1);
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
